// File: rtl/fetch_queue_if.sv
// Fetch-side bus for fetch_queue: instruction-memory port, execute redirect
// and the valid/ready queue head presented to decode.
interface fetch_queue_if;
  logic [31:0] imem_pc;
  logic [39:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_instr;
  logic [2:0]  out_len;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        halted;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_len,
    output out_pc,
    output out_illegal,
    output halted
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_len,
    input  out_pc,
    input  out_illegal,
    input  halted
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, pre-decodes instruction length from the
// opcode byte and buffers {pc, window, length, illegal} for decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_FETCH,
    ST_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        ent_pc_q    [DEPTH];
  logic [39:0]        ent_instr_q [DEPTH];
  logic [2:0]         ent_len_q   [DEPTH];
  logic               ent_ill_q   [DEPTH];

  logic [7:0]         opcode;
  logic [2:0]         dec_len;
  logic               dec_ill;
  logic               dec_stop;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;

  // Length pre-decode of the opcode byte at the current fetch PC.
  always_comb begin
    opcode  = bus.imem_instr[7:0];
    dec_len = 3'd1;
    dec_ill = 1'b0;
    case (opcode) inside
      8'h90, 8'hF4:                dec_len = 3'd1;
      8'hEB, 8'h74, 8'h75, 8'h01:  dec_len = 3'd2;
      8'h05, 8'hE9, [8'hB8:8'hBF]: dec_len = 3'd5;
      default: begin
        dec_len = 3'd1;
        dec_ill = 1'b1;
      end
    endcase
    dec_stop = dec_ill || (opcode == 8'hF4);
  end

  // Full is judged before the edge, so a same-cycle pop never makes room
  // for a same-cycle push; redirect suppresses both.
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    enq   = !full && (state_q == ST_FETCH) && !bus.redirect_valid;
    deq   = !empty && bus.out_ready && !bus.redirect_valid;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      state_d  = ST_FETCH;
      pc_d     = bus.redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        pc_d     = pc_q + 32'(dec_len);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (dec_stop) begin
          state_d = ST_HALT;
        end
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      ent_pc_q[wr_ptr_q]    <= pc_q;
      ent_instr_q[wr_ptr_q] <= bus.imem_instr;
      ent_len_q[wr_ptr_q]   <= dec_len;
      ent_ill_q[wr_ptr_q]   <= dec_ill;
    end
  end

  // Head fields are forced to zero while the queue is empty.
  always_comb begin
    bus.imem_pc     = pc_q;
    bus.halted      = (state_q == ST_HALT);
    bus.out_valid   = !empty;
    bus.out_pc      = '0;
    bus.out_instr   = '0;
    bus.out_len     = '0;
    bus.out_illegal = 1'b0;
    if (!empty) begin
      bus.out_pc      = ent_pc_q[rd_ptr_q];
      bus.out_instr   = ent_instr_q[rd_ptr_q];
      bus.out_len     = ent_len_q[rd_ptr_q];
      bus.out_illegal = ent_ill_q[rd_ptr_q];
    end
  end

endmodule
